// File: rtl/cpu_pkg.sv
// Shared core-wide constants and the fetch payload type.
package cpu_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_INC  = 4;

  localparam logic [INSTR_W-1:0] RESET_PC = '0;

  // One fetched instruction as handed to decode.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [INSTR_W-1:0] pc;
    logic [INSTR_W-1:0] updated_pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with registered storage; flush wins over push and pop.
module fetch_fifo #(
  parameter int unsigned WIDTH = 96,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];

  // Pointer and occupancy update.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_d = count_q + CW'(1);
      else if (!do_push && do_pop) count_d = count_q - CW'(1);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; cleared on reset so the head reads zero.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (!flush && do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: sequential SRAM issue, response queue, redirect flush.
module fetch_unit #(
  parameter int unsigned       DATA_W   = cpu_pkg::INSTR_W,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [DATA_W-1:0] RESET_PC = DATA_W'(cpu_pkg::RESET_PC),
  parameter int unsigned       PC_INC   = cpu_pkg::PC_INC
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic                   enable,
  output logic [DATA_W-1:0]      imem_addr,
  output logic                   imem_ren,
  input  logic [DATA_W-1:0]      imem_rdata,
  input  logic                   redirect_valid,
  input  logic [DATA_W-1:0]      redirect_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_instr,
  output logic [DATA_W-1:0]      out_pc,
  output logic [DATA_W-1:0]      out_updated_pc,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
  localparam int unsigned ENTRY_W = 3 * DATA_W;

  logic [DATA_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [DATA_W-1:0]  issued_pc_q, issued_pc_d;
  logic               inflight_q;
  logic               redirect_c, issue_c, push_c, pop_c;
  logic [CNT_W:0]     credit_c;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_empty, fifo_full;
  logic [ENTRY_W-1:0] push_data, head_data;
  logic               unused_c;

  // Queue slots already taken plus the one response that may still be on its way.
  assign credit_c   = {1'b0, fifo_count} + (CNT_W+1)'(inflight_q);
  assign redirect_c = enable && redirect_valid;
  // No requests while reset is held; otherwise issue only when a slot is reserved.
  assign issue_c    = arst_n && enable && !redirect_valid &&
                      (credit_c < (CNT_W+1)'(DEPTH));
  // A response arriving in a redirect cycle belongs to the old stream and is killed.
  assign push_c     = inflight_q && !redirect_c;
  assign pop_c      = enable && !fifo_empty && out_ready;

  assign imem_addr  = fetch_pc_q;
  assign imem_ren   = issue_c;
  assign push_data  = {imem_rdata, issued_pc_q, issued_pc_q + DATA_W'(PC_INC)};

  assign out_valid      = !fifo_empty;
  assign out_instr      = head_data[3*DATA_W-1:2*DATA_W];
  assign out_pc         = head_data[2*DATA_W-1:DATA_W];
  assign out_updated_pc = head_data[DATA_W-1:0];
  assign count          = fifo_count;

  assign unused_c = ^{redirect_pc[1:0], fifo_full};

  // Next fetch PC: redirect target, else advance on issue.
  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    issued_pc_d = issued_pc_q;
    if (redirect_c) begin
      fetch_pc_d = {redirect_pc[DATA_W-1:2], 2'b00};
    end else if (issue_c) begin
      fetch_pc_d  = fetch_pc_q + DATA_W'(PC_INC);
      issued_pc_d = fetch_pc_q;
    end
  end

  // Fetch PC, PC of the outstanding request, and outstanding flag.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      fetch_pc_q  <= RESET_PC;
      issued_pc_q <= '0;
      inflight_q  <= 1'b0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      issued_pc_q <= issued_pc_d;
      inflight_q  <= issue_c;
    end
  end

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .arst_n (arst_n),
    .push   (push_c),
    .pop    (pop_c),
    .flush  (redirect_c),
    .din    (push_data),
    .dout   (head_data),
    .count  (fifo_count),
    .empty  (fifo_empty),
    .full   (fifo_full)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a synchronous-read SRAM model.
module tb_fetch_unit;

  logic        clk;
  logic        arst_n;
  logic        enable;
  logic [31:0] imem_addr;
  logic        imem_ren;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_updated_pc;
  logic [2:0]  count;

  int checks;
  int failures;

  fetch_unit #(
    .DATA_W   (32),
    .DEPTH    (4),
    .RESET_PC (32'h0),
    .PC_INC   (4)
  ) dut (
    .clk            (clk),
    .arst_n         (arst_n),
    .enable         (enable),
    .imem_addr      (imem_addr),
    .imem_ren       (imem_ren),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_updated_pc (out_updated_pc),
    .count          (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: word at addr holds addr + 0x100, one-cycle read latency.
  always @(posedge clk or negedge arst_n) begin
    if (!arst_n)       imem_rdata <= '0;
    else if (imem_ren) imem_rdata <= imem_addr + 32'h100;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_reset();
    arst_n         = 1'b0;
    enable         = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    tick();
  endtask

  task automatic release_reset(input logic ena, input logic rdy);
    enable    = ena;
    out_ready = rdy;
    @(negedge clk);
    arst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (out_pc !== 32'h0) begin failures++; $display("FAIL reset_pc: got %h expected 0", out_pc); end
    checks++; if (out_instr !== 32'h0) begin failures++; $display("FAIL reset_instr: got %h expected 0", out_instr); end
    checks++; if (out_updated_pc !== 32'h0) begin failures++; $display("FAIL reset_upd: got %h expected 0", out_updated_pc); end
    checks++; if (imem_ren !== 1'b0) begin failures++; $display("FAIL reset_ren: got %b expected 0", imem_ren); end
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr: got %h expected 0", imem_addr); end
  endtask

  task automatic test_stream();
    apply_reset();
    release_reset(1'b1, 1'b1);
    checks++; if (imem_ren !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL stream_first_issue: got ren=%b addr=%h expected ren=1 addr=0", imem_ren, imem_addr); end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_valid_c1: got %b expected 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin failures++; $display("FAIL stream_valid_c2: got valid=%b pc=%h expected 1/0", out_valid, out_pc); end
    checks++; if (out_instr !== 32'h100 || out_updated_pc !== 32'h4) begin failures++; $display("FAIL stream_head_c2: got instr=%h upd=%h expected 100/4", out_instr, out_updated_pc); end
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'(4*i)) begin failures++; $display("FAIL stream_pc[%0d]: got valid=%b pc=%h expected 1/%h", i, out_valid, out_pc, 32'(4*i)); end
      checks++; if (out_instr !== 32'(4*i + 256) || out_updated_pc !== 32'(4*i + 4)) begin failures++; $display("FAIL stream_data[%0d]: got instr=%h upd=%h", i, out_instr, out_updated_pc); end
      checks++; if (count !== 3'd1) begin failures++; $display("FAIL stream_count[%0d]: got %0d expected 1", i, count); end
    end
  endtask

  task automatic test_full();
    int issues;
    issues = 0;
    apply_reset();
    release_reset(1'b1, 1'b0);
    for (int c = 0; c < 8; c++) begin
      if (imem_ren === 1'b1) issues++;
      tick();
    end
    checks++; if (issues !== 4) begin failures++; $display("FAIL full_issues: got %0d expected 4", issues); end
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL full_count: got %0d expected 4", count); end
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin failures++; $display("FAIL full_head: got valid=%b pc=%h expected 1/0", out_valid, out_pc); end
    out_ready = 1'b1;
    #1;
    checks++; if (imem_ren !== 1'b0) begin failures++; $display("FAIL full_no_credit: got ren=%b expected 0", imem_ren); end
    for (int k = 1; k <= 5; k++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'(4*k)) begin failures++; $display("FAIL full_drain[%0d]: got valid=%b pc=%h expected 1/%h", k, out_valid, out_pc, 32'(4*k)); end
      if (k == 1) begin
        checks++; if (count !== 3'd3) begin failures++; $display("FAIL full_count_after_pop: got %0d expected 3", count); end
        checks++; if (imem_ren !== 1'b1 || imem_addr !== 32'h10) begin failures++; $display("FAIL full_resume: got ren=%b addr=%h expected 1/10", imem_ren, imem_addr); end
      end
    end
  endtask

  task automatic test_redirect();
    apply_reset();
    release_reset(1'b1, 1'b0);
    for (int c = 0; c < 4; c++) tick();
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL redir_pre_count: got %0d expected 3", count); end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h43;
    #1;
    checks++; if (imem_ren !== 1'b0) begin failures++; $display("FAIL redir_no_issue: got %b expected 0", imem_ren); end
    tick();
    checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL redir_flush: got count=%0d valid=%b expected 0/0", count, out_valid); end
    redirect_valid = 1'b0;
    #1;
    checks++; if (imem_ren !== 1'b1 || imem_addr !== 32'h40) begin failures++; $display("FAIL redir_target_issue: got ren=%b addr=%h expected 1/40", imem_ren, imem_addr); end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL redir_valid_r2: got %b expected 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h40) begin failures++; $display("FAIL redir_head: got valid=%b pc=%h expected 1/40", out_valid, out_pc); end
    checks++; if (out_instr !== 32'h140 || out_updated_pc !== 32'h44) begin failures++; $display("FAIL redir_head_data: got instr=%h upd=%h expected 140/44", out_instr, out_updated_pc); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_pc !== 32'h44) begin failures++; $display("FAIL redir_next: got %h expected 44", out_pc); end
  endtask

  task automatic test_redirect_pop();
    apply_reset();
    release_reset(1'b1, 1'b1);
    for (int c = 0; c < 3; c++) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    tick();
    checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL rpop_flush: got count=%0d valid=%b expected 0/0", count, out_valid); end
    redirect_valid = 1'b0;
    tick();
    tick();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h200) begin failures++; $display("FAIL rpop_target: got valid=%b pc=%h expected 1/200", out_valid, out_pc); end
  endtask

  task automatic test_enable();
    apply_reset();
    release_reset(1'b1, 1'b1);
    for (int c = 0; c < 3; c++) tick();
    enable = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h4 || count !== 3'd2) begin failures++; $display("FAIL en_hold[%0d]: got valid=%b pc=%h count=%0d expected 1/4/2", c, out_valid, out_pc, count); end
      checks++; if (imem_addr !== 32'hC || imem_ren !== 1'b0) begin failures++; $display("FAIL en_frozen[%0d]: got addr=%h ren=%b expected C/0", c, imem_addr, imem_ren); end
    end
    enable = 1'b1;
    #1;
    checks++; if (imem_ren !== 1'b1) begin failures++; $display("FAIL en_resume_issue: got %b expected 1", imem_ren); end
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'(4 + 4*k)) begin failures++; $display("FAIL en_resume[%0d]: got valid=%b pc=%h expected 1/%h", k, out_valid, out_pc, 32'(4 + 4*k)); end
    end
  endtask

  task automatic test_wrap_and_reset();
    apply_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    release_reset(1'b1, 1'b1);
    tick();
    redirect_valid = 1'b0;
    #1;
    checks++; if (imem_ren !== 1'b1 || imem_addr !== 32'hFFFF_FFF8) begin failures++; $display("FAIL wrap_issue: got ren=%b addr=%h expected 1/FFFFFFF8", imem_ren, imem_addr); end
    tick();
    tick();
    checks++; if (out_pc !== 32'hFFFF_FFF8 || out_instr !== 32'hF8 || out_updated_pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_0: got pc=%h instr=%h upd=%h", out_pc, out_instr, out_updated_pc); end
    tick();
    checks++; if (out_pc !== 32'hFFFF_FFFC || out_instr !== 32'hFC || out_updated_pc !== 32'h0) begin failures++; $display("FAIL wrap_1: got pc=%h instr=%h upd=%h", out_pc, out_instr, out_updated_pc); end
    tick();
    checks++; if (out_pc !== 32'h0 || out_instr !== 32'h100 || out_updated_pc !== 32'h4) begin failures++; $display("FAIL wrap_2: got pc=%h instr=%h upd=%h", out_pc, out_instr, out_updated_pc); end
    arst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin failures++; $display("FAIL midrst_state: got valid=%b count=%0d expected 0/0", out_valid, count); end
    checks++; if (out_pc !== 32'h0 || out_instr !== 32'h0 || out_updated_pc !== 32'h0) begin failures++; $display("FAIL midrst_head: got pc=%h instr=%h upd=%h expected 0", out_pc, out_instr, out_updated_pc); end
    checks++; if (imem_ren !== 1'b0 || imem_addr !== 32'h0) begin failures++; $display("FAIL midrst_imem: got ren=%b addr=%h expected 0/0", imem_ren, imem_addr); end
    @(negedge clk);
    arst_n = 1'b1;
    #1;
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_c1: got valid=%b expected 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'h100) begin failures++; $display("FAIL midrst_restart: got valid=%b pc=%h instr=%h expected 1/0/100", out_valid, out_pc, out_instr); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    arst_n         = 1'b0;
    enable         = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    test_reset();
    test_stream();
    test_full();
    test_redirect();
    test_redirect_pop();
    test_enable();
    test_wrap_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
